// File: rtl/display_scan_controller.sv
// Four-slot seven-segment scan controller: blank/drive timing per slot, active-low anode select,
// and a per-frame coherent snapshot of the four displayed operands.
module display_scan_controller #(
    parameter int unsigned BLANK_CYCLES = 1000,
    parameter int unsigned DRIVE_CYCLES = 99000,
    parameter int unsigned CNT_W        = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] digit_en,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [3:0] AplusB,
    input  logic [3:0] AminusB,
    output logic [3:0] anode,
    output logic [3:0] A_q,
    output logic [3:0] B_q,
    output logic [3:0] AplusB_q,
    output logic [3:0] AminusB_q,
    output logic [1:0] slot,
    output logic       frame_done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BLANK = 2'd1;
    localparam logic [1:0] S_DRIVE = 2'd2;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYCLES - 1);
    // With no blanking a slot goes straight from one drive phase into the next.
    localparam logic [1:0] S_SLOT_START = (BLANK_CYCLES == 0) ? S_DRIVE : S_BLANK;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_slot;
    logic [3:0]       r_anode;
    logic             r_frame_done;
    logic [3:0]       r_a_q;
    logic [3:0]       r_b_q;
    logic [3:0]       r_sum_q;
    logic [3:0]       r_diff_q;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       w_slot_nxt;
    logic             w_wrap;
    logic             w_load;
    logic [3:0]       w_anode_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_slot_nxt  = r_slot;
        w_wrap      = 1'b0;
        w_load      = 1'b0;
        if (!enable) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_slot_nxt  = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_SLOT_START;
                    w_cnt_nxt   = '0;
                    w_slot_nxt  = '0;
                    w_load      = 1'b1;
                end
                S_BLANK: begin
                    if (r_cnt == BLANK_LAST) begin
                        w_state_nxt = S_DRIVE;
                        w_cnt_nxt   = '0;
                    end
                end
                S_DRIVE: begin
                    if (r_cnt == DRIVE_LAST) begin
                        w_state_nxt = S_SLOT_START;
                        w_cnt_nxt   = '0;
                        w_slot_nxt  = r_slot + 2'd1;
                        w_wrap      = (r_slot == 2'd3);
                        w_load      = (r_slot == 2'd3);
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_slot_nxt  = '0;
                end
            endcase
        end
    end

    // Anode is decoded from the next state so the registered output lines up with the phase.
    always_comb begin
        w_anode_nxt = '1;
        if (w_state_nxt == S_DRIVE && digit_en[w_slot_nxt]) begin
            case (w_slot_nxt)
                2'd0:    w_anode_nxt = 4'b1110;
                2'd1:    w_anode_nxt = 4'b1101;
                2'd2:    w_anode_nxt = 4'b1011;
                default: w_anode_nxt = 4'b0111;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_slot       <= '0;
            r_anode      <= '1;
            r_frame_done <= 1'b0;
            r_a_q        <= '0;
            r_b_q        <= '0;
            r_sum_q      <= '0;
            r_diff_q     <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_slot       <= w_slot_nxt;
            r_anode      <= w_anode_nxt;
            r_frame_done <= w_wrap;
            if (w_load) begin
                r_a_q    <= A;
                r_b_q    <= B;
                r_sum_q  <= AplusB;
                r_diff_q <= AminusB;
            end
        end
    end

    assign anode      = r_anode;
    assign slot       = r_slot;
    assign frame_done = r_frame_done;
    assign A_q        = r_a_q;
    assign B_q        = r_b_q;
    assign AplusB_q   = r_sum_q;
    assign AminusB_q  = r_diff_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: two instances (2/4 and 0/4 blank/drive) checked every cycle
// against an arithmetic scan model, plus hand-computed literal expectations.
module tb_display_scan_controller;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] digit_en;
    logic [3:0] A, B, AplusB, AminusB;

    logic [1:0][3:0] o_anode, o_aq, o_bq, o_sq, o_dq;
    logic [1:0][1:0] o_slot;
    logic [1:0]      o_fd;

    logic [1:0][3:0] e_anode, e_aq, e_bq, e_sq, e_dq;
    logic [1:0][1:0] e_slot;
    logic [1:0]      e_fd;
    logic [1:0]      m_act;
    int              m_t [2];
    logic            m_valid;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    display_scan_controller #(.BLANK_CYCLES(2), .DRIVE_CYCLES(4), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .enable(enable), .digit_en(digit_en),
        .A(A), .B(B), .AplusB(AplusB), .AminusB(AminusB),
        .anode(o_anode[0]), .A_q(o_aq[0]), .B_q(o_bq[0]), .AplusB_q(o_sq[0]),
        .AminusB_q(o_dq[0]), .slot(o_slot[0]), .frame_done(o_fd[0]));

    display_scan_controller #(.BLANK_CYCLES(0), .DRIVE_CYCLES(4), .CNT_W(3)) dut0 (
        .clk(clk), .reset(reset), .enable(enable), .digit_en(digit_en),
        .A(A), .B(B), .AplusB(AplusB), .AminusB(AminusB),
        .anode(o_anode[1]), .A_q(o_aq[1]), .B_q(o_bq[1]), .AplusB_q(o_sq[1]),
        .AminusB_q(o_dq[1]), .slot(o_slot[1]), .frame_done(o_fd[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int blank_of(int k);
        return (k == 0) ? 2 : 0;
    endfunction

    function automatic int next_t(logic act, int t);
        return act ? t + 1 : 0;
    endfunction

    // t counts cycles since the scan started; blanking occupies the head of each slot period.
    function automatic logic [3:0] model_anode(int t, int blank, logic [3:0] den);
        int p;
        int s;
        logic [3:0] one;
        p   = blank + 4;
        s   = (t / p) % 4;
        one = 4'b0001;
        if ((t % p) < blank || !den[s]) return 4'b1111;
        return ~(one << s);
    endfunction

    function automatic logic [1:0] model_slot(int t, int blank);
        return 2'((t / (blank + 4)) % 4);
    endfunction

    always @(posedge clk) begin
        if (reset) m_valid <= 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_act[k] <= 1'b0; m_t[k] <= 0;
                e_anode[k] <= 4'b1111; e_slot[k] <= 2'd0; e_fd[k] <= 1'b0;
                e_aq[k] <= 4'd0; e_bq[k] <= 4'd0; e_sq[k] <= 4'd0; e_dq[k] <= 4'd0;
            end else if (!enable) begin
                m_act[k] <= 1'b0; m_t[k] <= 0;
                e_anode[k] <= 4'b1111; e_slot[k] <= 2'd0; e_fd[k] <= 1'b0;
            end else begin
                m_act[k]   <= 1'b1;
                m_t[k]     <= next_t(m_act[k], m_t[k]);
                e_anode[k] <= model_anode(next_t(m_act[k], m_t[k]), blank_of(k), digit_en);
                e_slot[k]  <= model_slot(next_t(m_act[k], m_t[k]), blank_of(k));
                e_fd[k]    <= m_act[k] && (next_t(m_act[k], m_t[k]) % (4 * (blank_of(k) + 4)) == 0);
                if (!m_act[k] || (next_t(m_act[k], m_t[k]) % (4 * (blank_of(k) + 4)) == 0)) begin
                    e_aq[k] <= A; e_bq[k] <= B; e_sq[k] <= AplusB; e_dq[k] <= AminusB;
                end
            end
        end
    end

    task automatic cmp(string nm, int k, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d cycle=%0d got=%0h want=%0h", nm, k, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid === 1'b1) begin
            for (int k = 0; k < 2; k++) begin
                cmp("anode",      k, 32'(o_anode[k]), 32'(e_anode[k]));
                cmp("slot",       k, 32'(o_slot[k]),  32'(e_slot[k]));
                cmp("frame_done", k, 32'(o_fd[k]),    32'(e_fd[k]));
                cmp("A_q",        k, 32'(o_aq[k]),    32'(e_aq[k]));
                cmp("B_q",        k, 32'(o_bq[k]),    32'(e_bq[k]));
                cmp("AplusB_q",   k, 32'(o_sq[k]),    32'(e_sq[k]));
                cmp("AminusB_q",  k, 32'(o_dq[k]),    32'(e_dq[k]));
                cmp("one_hot_low", k, 32'($countones(~o_anode[k]) <= 1), 32'd1);
            end
        end
    end

    task automatic go(int c);
        while (cyc < c) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; digit_en = 4'b1111;
        A = 4'd1; B = 4'd2; AplusB = 4'd3; AminusB = 4'd4;
        repeat (3) @(negedge clk);
        cmp("lit_reset_anode", 0, 32'(o_anode[0]), 32'hF);
        cmp("lit_reset_q", 0, 32'(o_aq[0]), 32'h0);
        reset = 1'b0;
        cyc = 0;

        // basic scan and snapshot coherence
        go(1);  cmp("lit_c1_anode", 0, 32'(o_anode[0]), 32'hF);
                cmp("lit_c1_anode", 1, 32'(o_anode[1]), 32'hE);
        go(3);  cmp("lit_c3_anode", 0, 32'(o_anode[0]), 32'hE);
        go(5);  cmp("lit_c5_anode", 1, 32'(o_anode[1]), 32'hD);
        go(7);  cmp("lit_c7_anode", 0, 32'(o_anode[0]), 32'hF);
        go(9);  cmp("lit_c9_anode", 0, 32'(o_anode[0]), 32'hD);
                cmp("lit_c9_anode", 1, 32'(o_anode[1]), 32'hB);
        go(10); A = 4'd9;
        go(13); cmp("lit_c13_anode", 1, 32'(o_anode[1]), 32'h7);
        go(15); cmp("lit_c15_anode", 0, 32'(o_anode[0]), 32'hB);
                cmp("lit_c15_slot", 0, 32'(o_slot[0]), 32'd2);
        go(17); cmp("lit_c17_fd", 1, 32'(o_fd[1]), 32'd1);
                cmp("lit_c17_Aq", 1, 32'(o_aq[1]), 32'd9);
        go(21); cmp("lit_c21_anode", 0, 32'(o_anode[0]), 32'h7);
        go(24); cmp("lit_c24_fd", 0, 32'(o_fd[0]), 32'd0);
                cmp("lit_c24_Aq", 0, 32'(o_aq[0]), 32'd1);
                cmp("lit_c24_Bq", 0, 32'(o_bq[0]), 32'd2);
                cmp("lit_c24_Sq", 0, 32'(o_sq[0]), 32'd3);
                cmp("lit_c24_Dq", 0, 32'(o_dq[0]), 32'd4);
        go(25); cmp("lit_c25_fd", 0, 32'(o_fd[0]), 32'd1);
                cmp("lit_c25_Aq", 0, 32'(o_aq[0]), 32'd9);
                digit_en = 4'b1010;

        // digit mask
        go(26); cmp("lit_c26_fd", 0, 32'(o_fd[0]), 32'd0);
        go(27); cmp("lit_c27_anode", 0, 32'(o_anode[0]), 32'hF);
        go(33); cmp("lit_c33_anode", 0, 32'(o_anode[0]), 32'hD);
                cmp("lit_c33_fd", 1, 32'(o_fd[1]), 32'd1);
        go(39); cmp("lit_c39_anode", 0, 32'(o_anode[0]), 32'hF);
        go(45); cmp("lit_c45_anode", 0, 32'(o_anode[0]), 32'h7);
        go(49); cmp("lit_c49_fd", 0, 32'(o_fd[0]), 32'd1);
                digit_en = 4'b1111;

        // enable drop during slot 2 drive, then restart
        go(64); enable = 1'b0; A = 4'd5;
        go(65); cmp("lit_c65_anode", 0, 32'(o_anode[0]), 32'hF);
                cmp("lit_c65_slot", 0, 32'(o_slot[0]), 32'd0);
                cmp("lit_c65_fd", 0, 32'(o_fd[0]), 32'd0);
                cmp("lit_c65_Aq", 0, 32'(o_aq[0]), 32'd9);
        go(67); enable = 1'b1;
        go(68); cmp("lit_c68_Aq", 0, 32'(o_aq[0]), 32'd5);
                cmp("lit_c68_anode", 0, 32'(o_anode[0]), 32'hF);
                cmp("lit_c68_anode", 1, 32'(o_anode[1]), 32'hE);
        go(70); cmp("lit_c70_anode", 0, 32'(o_anode[0]), 32'hE);

        // reset pulse during slot 3 drive
        go(89); cmp("lit_c89_anode", 0, 32'(o_anode[0]), 32'h7);
                reset = 1'b1;
        go(90); cmp("lit_c90_anode", 0, 32'(o_anode[0]), 32'hF);
                cmp("lit_c90_slot", 0, 32'(o_slot[0]), 32'd0);
                cmp("lit_c90_Aq", 0, 32'(o_aq[0]), 32'd0);
                cmp("lit_c90_fd", 0, 32'(o_fd[0]), 32'd0);
                reset = 1'b0;
        go(91); cmp("lit_c91_Aq", 0, 32'(o_aq[0]), 32'd5);
        go(107); cmp("lit_c107_fd", 1, 32'(o_fd[1]), 32'd1);
        go(115); cmp("lit_c115_fd", 0, 32'(o_fd[0]), 32'd1);
        go(120);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
